sprite_blitter: RTL and testbench

//  Copies one SPR_W x SPR_H sprite from a synchronous colour ROM onto the 320x240

---
 rtl/sprite_blitter_if.sv | 27 ++
 rtl/sprite_blitter.sv | 93 +++++++++
 tb/tb_sprite_blitter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Plot/ROM bus of the sprite blitter: blit request, sprite ROM port and pixel stream.
// The master side drives requests and ROM data. The slave side is the blitter.
interface sprite_blitter_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [8:0]        pos_x;
    logic [7:0]        pos_y;
    logic [ADDR_W-1:0] rom_addr;
    logic [2:0]        rom_q;
    logic [8:0]        x;
    logic [7:0]        y;
    logic [2:0]        colour;
    logic              writeEn;
    logic              busy;
    logic              done;

    modport master (
        output start, pos_x, pos_y, rom_q,
        input  rom_addr, x, y, colour, writeEn, busy, done
    );

    modport slave (
        input  start, pos_x, pos_y, rom_q,
        output rom_addr, x, y, colour, writeEn, busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// Copies an SPR_W x SPR_H sprite from a synchronous ROM onto the 320x240 plot port.
// Transparent and off-screen pixels still use a slot, but they do not strobe writeEn.
module sprite_blitter #(
    parameter int          SPR_W  = 16,
    parameter int          SPR_H  = 16,
    parameter int          ADDR_W = 8,
    parameter logic [2:0]  TRANSP = 3'b101
) (
    input  logic             clock,
    input  logic             reset,
    sprite_blitter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t     state, state_nxt;
    logic [8:0] org_x;
    logic [7:0] org_y;
    logic [8:0] cx, cx_d;
    logic [7:0] cy, cy_d;
    logic [1:0] vld_pipe;
    logic       last_addr;
    logic [9:0] px;
    logic [8:0] py;

    assign last_addr = (cx == 9'(SPR_W - 1)) && (cy == 8'(SPR_H - 1));
    assign px        = {1'b0, org_x} + {1'b0, cx_d};
    assign py        = {1'b0, org_y} + {1'b0, cy_d};
    assign bus.busy  = (state == FETCH) || (state == DRAIN);
    assign bus.done  = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = FETCH;
            FETCH:   if (last_addr) state_nxt = DRAIN;
            // Leave once the final pixel sits in the output stage.
            DRAIN:   if (!vld_pipe[0] && vld_pipe[1]) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            org_x        <= '0;
            org_y        <= '0;
            cx           <= '0;
            cy           <= '0;
            cx_d         <= '0;
            cy_d         <= '0;
            vld_pipe     <= '0;
            bus.rom_addr <= '0;
            bus.x        <= '0;
            bus.y        <= '0;
            bus.colour   <= '0;
            bus.writeEn  <= 1'b0;
        end else begin
            // The cx/cy delay stage matches the one-cycle ROM latency.
            vld_pipe    <= {vld_pipe[0], state == FETCH};
            cx_d        <= cx;
            cy_d        <= cy;
            bus.x       <= px[8:0];
            bus.y       <= py[7:0];
            bus.colour  <= bus.rom_q;
            bus.writeEn <= vld_pipe[0] && (bus.rom_q != TRANSP) &&
                           (px < 10'd320) && (py < 9'd240);
            case (state)
                IDLE: if (bus.start) begin
                    org_x        <= bus.pos_x;
                    org_y        <= bus.pos_y;
                    cx           <= '0;
                    cy           <= '0;
                    bus.rom_addr <= '0;
                end
                FETCH: if (!last_addr) begin
                    bus.rom_addr <= bus.rom_addr + 1'b1;
                    if (cx == 9'(SPR_W - 1)) begin
                        cx <= '0;
                        cy <= cy + 8'd1;
                    end else begin
                        cx <= cx + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a 16x16 instance with a ROM model and a 1x1 instance.
// A negedge monitor checks every pixel slot against a reference walk of the sprite.
`define CHK(tag, obs, expv) \
    tests++; \
    assert ((obs) === (expv)) else begin \
        fails++; \
        $error("FAIL %s: got %0d expected %0d", tag, obs, expv); \
    end

module tb_sprite_blitter;
    localparam logic [2:0] TRANSP = 3'b101;
    localparam logic [2:0] OPAQUE = 3'b010;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    sprite_blitter_if #(.ADDR_W(8)) bus ();
    sprite_blitter_if #(.ADDR_W(1)) bus1 ();

    sprite_blitter #(.SPR_W(16), .SPR_H(16), .ADDR_W(8), .TRANSP(TRANSP)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    sprite_blitter #(.SPR_W(1), .SPR_H(1), .ADDR_W(1), .TRANSP(TRANSP)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic [2:0] rom [256];
    always @(posedge clock) bus.rom_q  <= rom[bus.rom_addr];
    always @(posedge clock) bus1.rom_q <= OPAQUE;

    // Stimulus-side test context (written only by the initial block)
    int   t0      = -1000;
    int   exp_x   = 0;
    int   exp_y   = 0;
    int   test_id = 0;
    logic mon_on  = 1'b0;

    // Monitor-side counters (written only by the monitor)
    int cur_id = 0;
    int pulses, busy_cnt, done_cnt, done_cyc, seq_bad, clip_bad;
    int first_x, first_y, first_cyc, last_x, last_y, last_cyc;

    always @(negedge clock) begin : monitor
        int s, mx, my;
        logic ew;
        if (cur_id != test_id) begin
            cur_id = test_id;
            pulses = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
            seq_bad = 0; clip_bad = 0; first_cyc = 0; last_cyc = 0;
            first_x = 0; first_y = 0; last_x = 0; last_y = 0;
        end
        s  = cyc - t0 - 3;
        mx = 0;
        my = 0;
        ew = 1'b0;
        if (s >= 0 && s < 256) begin
            mx = exp_x + s % 16;
            my = exp_y + s / 16;
            ew = (rom[s] != TRANSP) && (mx < 320) && (my < 240);
        end
        if (mon_on) begin
            if (bus.writeEn !== ew) seq_bad++;
            else if (ew && (bus.x !== 9'(mx) || bus.y !== 8'(my) || bus.colour !== rom[s]))
                seq_bad++;
        end
        if (bus.writeEn === 1'b1) begin
            if (pulses == 0) begin first_x = bus.x; first_y = bus.y; first_cyc = cyc - t0; end
            last_x = bus.x; last_y = bus.y; last_cyc = cyc - t0;
            if (bus.x >= 9'd320 || bus.y >= 8'd240) clip_bad++;
            pulses++;
        end
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc - t0; end
    end

    task automatic blit(input logic [8:0] px, input logic [7:0] py);
        @(negedge clock);
        exp_x = px; exp_y = py;
        bus.pos_x = px; bus.pos_y = py;
        t0 = cyc;
        test_id++;
        mon_on = 1'b1;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic fill_rom(input logic with_transp);
        for (int i = 0; i < 256; i++)
            rom[i] = (with_transp && i < 240 && i % 6 == 0) ? TRANSP : OPAQUE;
    endtask

    initial begin
        int t1;
        bus.start = 1'b0; bus.pos_x = '0; bus.pos_y = '0;
        bus1.start = 1'b0; bus1.pos_x = '0; bus1.pos_y = '0;
        fill_rom(1'b0);

        // Reset state
        repeat (3) @(negedge clock);
        `CHK("rst_rom_addr", bus.rom_addr, 8'd0)
        `CHK("rst_x", bus.x, 9'd0)
        `CHK("rst_y", bus.y, 8'd0)
        `CHK("rst_colour", bus.colour, 3'd0)
        `CHK("rst_writeEn", bus.writeEn, 1'b0)
        `CHK("rst_busy", bus.busy, 1'b0)
        `CHK("rst_done", bus.done, 1'b0)
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 1: opaque sprite at (10,20)
        blit(9'd10, 8'd20);
        wait_to(t0 + 266);
        `CHK("t1_pulses", pulses, 256)
        `CHK("t1_seq", seq_bad, 0)
        `CHK("t1_first_x", first_x, 10)
        `CHK("t1_first_y", first_y, 20)
        `CHK("t1_first_cyc", first_cyc, 3)
        `CHK("t1_last_x", last_x, 25)
        `CHK("t1_last_y", last_y, 35)
        `CHK("t1_last_cyc", last_cyc, 258)
        `CHK("t1_busy_cycles", busy_cnt, 258)
        `CHK("t1_done_cnt", done_cnt, 1)
        `CHK("t1_done_cyc", done_cyc, 259)
        `CHK("t1_rom_addr_hold", bus.rom_addr, 8'd255)

        // 2: forty transparent entries
        fill_rom(1'b1);
        blit(9'd10, 8'd20);
        wait_to(t0 + 266);
        `CHK("t2_pulses", pulses, 216)
        `CHK("t2_seq", seq_bad, 0)

        // 3: clipped against the bottom-right corner
        fill_rom(1'b0);
        blit(9'd312, 8'd230);
        wait_to(t0 + 266);
        `CHK("t3_pulses", pulses, 80)
        `CHK("t3_clip", clip_bad, 0)
        `CHK("t3_seq", seq_bad, 0)
        `CHK("t3_done_cyc", done_cyc, 259)

        // 4: second start mid-blit is ignored
        blit(9'd10, 8'd20);
        wait_to(t0 + 50);
        bus.pos_x = 9'd100; bus.pos_y = 8'd100; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_to(t0 + 280);
        `CHK("t4_pulses", pulses, 256)
        `CHK("t4_seq", seq_bad, 0)
        `CHK("t4_done_cnt", done_cnt, 1)
        `CHK("t4_done_cyc", done_cyc, 259)

        // 5: reset at pixel slot 100, then a clean blit
        blit(9'd10, 8'd20);
        wait_to(t0 + 103);
        `CHK("t5_slot100_we", bus.writeEn, 1'b1)
        mon_on = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        `CHK("t5_we_after_rst", bus.writeEn, 1'b0)
        `CHK("t5_busy_after_rst", bus.busy, 1'b0)
        reset = 1'b0;
        wait_to(t0 + 300);
        `CHK("t5_no_done", done_cnt, 0)
        `CHK("t5_pulses", pulses, 101)
        blit(9'd10, 8'd20);
        wait_to(t0 + 266);
        `CHK("t5_retry_pulses", pulses, 256)
        `CHK("t5_retry_seq", seq_bad, 0)
        `CHK("t5_retry_done_cyc", done_cyc, 259)

        // 6: 1x1 sprite at (319,239)
        @(negedge clock);
        bus1.pos_x = 9'd319; bus1.pos_y = 8'd239; bus1.start = 1'b1;
        t1 = cyc;
        @(negedge clock);
        bus1.start = 1'b0;
        wait_to(t1 + 3);
        `CHK("t6_we", bus1.writeEn, 1'b1)
        `CHK("t6_x", bus1.x, 9'd319)
        `CHK("t6_y", bus1.y, 8'd239)
        `CHK("t6_colour", bus1.colour, OPAQUE)
        `CHK("t6_done_early", bus1.done, 1'b0)
        wait_to(t1 + 4);
        `CHK("t6_done", bus1.done, 1'b1)
        `CHK("t6_we_off", bus1.writeEn, 1'b0)
        wait_to(t1 + 5);
        `CHK("t6_done_pulse", bus1.done, 1'b0)

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
